// File: rtl/uart_rx_pkt_fifo_pkg.sv
// Shared widths and the FIFO entry layout for the UART receive packet buffer.
package uart_rx_pkt_fifo_pkg;

    localparam int RX_BYTE_W  = 8;
    localparam int RX_ENTRY_W = RX_BYTE_W + 1;

    typedef struct packed {
        logic                 last;
        logic [RX_BYTE_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_pkt_fifo_sync_fifo.sv
// Register-array FIFO with first-word fall-through output; writes while full are dropped.
// Read data is gated to zero when empty so the output is deterministic after reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             empty;
    logic             wr_fire;
    logic             rd_fire;

    // Full is judged on the pre-read state: a same-cycle read never frees room for a write.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_fire = wr_vld && !full;
    assign rd_fire = rd_vld && rd_rdy;
    assign rd_vld  = !empty;
    assign rd_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/uart_rx_pkt_fifo.sv
// Buffers UART receive bytes into a last-tagged FIFO, counting complete packets held.
// Each byte waits in staging until the next byte or end-of-packet decides its last flag.
module uart_rx_pkt_fifo
    import uart_rx_pkt_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_ready,
    input  logic [RX_BYTE_W-1:0]       rx_data,
    input  logic                       rx_eop,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RX_BYTE_W-1:0]       out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] pkt_count,
    output logic                       overflow
);

    localparam int CW = $clog2(DEPTH+1);

    logic                 stg_valid_q, stg_valid_d;
    logic [RX_BYTE_W-1:0] stg_data_q, stg_data_d;
    logic [CW-1:0]        pkt_count_q, pkt_count_d;
    logic                 overflow_q, overflow_d;

    logic                  commit;
    rx_entry_t             commit_entry;
    logic                  fifo_full;
    logic [RX_ENTRY_W-1:0] fifo_rd_dat;
    rx_entry_t             head;
    logic                  pkt_inc;
    logic                  pkt_dec;

    // A new byte or an eop both push the staged byte out; eop alone marks it last.
    assign commit            = stg_valid_q && (rx_ready || rx_eop);
    assign commit_entry.last = rx_eop;
    assign commit_entry.data = stg_data_q;

    sync_fifo #(
        .WIDTH (RX_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (commit),
        .wr_dat (commit_entry),
        .full   (fifo_full),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (fifo_rd_dat)
    );

    assign head     = fifo_rd_dat;
    assign out_data = head.data;
    assign out_last = head.last;

    assign pkt_inc = commit && commit_entry.last && !fifo_full;
    assign pkt_dec = out_valid && out_ready && out_last;

    always_comb begin
        stg_valid_d = stg_valid_q;
        stg_data_d  = stg_data_q;
        pkt_count_d = pkt_count_q;
        overflow_d  = overflow_q || (commit && fifo_full);

        if (rx_ready) begin
            stg_valid_d = 1'b1;
            stg_data_d  = rx_data;
        end else if (rx_eop) begin
            stg_valid_d = 1'b0;
        end

        case ({pkt_inc, pkt_dec})
            2'b10:   pkt_count_d = pkt_count_q + CW'(1);
            2'b01:   pkt_count_d = pkt_count_q - CW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_data_q  <= '0;
            pkt_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_data_q  <= stg_data_d;
            pkt_count_q <= pkt_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pkt_count = pkt_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_pkt_fifo.sv
// Scoreboard bench: stimulus pushes expected {last,data} entries, a monitor pops on each read handshake.
module tb_uart_rx_pkt_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_eop = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic [4:0] pkt_count;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q [$];
    bit wrap_on = 1'b0;

    always #5 clk = ~clk;

    uart_rx_pkt_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_eop    (rx_eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .pkt_count (pkt_count),
        .overflow  (overflow)
    );

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_entry: got last=%0b data=%02h, expected no output", out_last, out_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    failures++;
                    $display("FAIL out_entry: got last=%0b data=%02h, expected last=%0b data=%02h",
                             out_last, out_data, e[8], e[7:0]);
                end
            end
        end
        if (wrap_on) begin
            checks++;
            if (pkt_count > 5'd4) begin
                failures++;
                $display("FAIL wrap_pkt_count_range: got %0d, expected <= 4", pkt_count);
            end
        end
    end

    // Random consumer readiness during the wrap-around phase only.
    always @(posedge clk) begin
        if (wrap_on) begin
            #1;
            if (wrap_on) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] d, input logic e);
        rx_ready = r;
        rx_data  = d;
        rx_eop   = e;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        rx_eop   = 1'b0;
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_pkt_count", pkt_count, 0);
        chk("reset_overflow", overflow, 0);

        // Single packet, consumer always ready.
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b0, 8'h42});
        exp_q.push_back({1'b1, 8'h43});
        drive(1, 8'h41, 0);
        drive(1, 8'h42, 0);
        drive(1, 8'h43, 0);
        drive(0, 8'h00, 1);
        chk("single_pkt_count_1", pkt_count, 1);
        wait_drain("single");
        chk("single_pkt_count_0", pkt_count, 0);

        // Simultaneous byte strobe and eop.
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        drive(1, 8'h10, 0);
        drive(1, 8'h20, 1);
        drive(0, 8'h00, 1);
        chk("simul_pkt_count_2", pkt_count, 2);
        out_ready = 1'b1;
        wait_drain("simul");
        chk("simul_pkt_count_0", pkt_count, 0);

        // Overflow: 17 commits into 16 entries, consumer stalled.
        do_reset();
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 8'(8'h80 + i)});
        for (int i = 0; i < 18; i++) begin
            drive(1, 8'(8'h80 + i), 0);
            if (i == 16) begin
                chk("ovf_before_drop", overflow, 0);
                chk("ovf_full_valid", out_valid, 1);
            end
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_pkt_count", pkt_count, 0);
        out_ready = 1'b1;
        wait_drain("ovf");
        chk("ovf_sticky", overflow, 1);
        chk("ovf_empty", out_valid, 0);
        do_reset();
        chk("ovf_cleared", overflow, 0);

        // Wrap-around: 4 packets of 10 with random consumer readiness.
        wrap_on = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 10; j++) begin
                int n;
                n = 0;
                while (exp_q.size() >= 14 && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                exp_q.push_back({(j == 9), 8'(p * 10 + j + 1)});
                drive(1, 8'(p * 10 + j + 1), 0);
            end
            drive(0, 8'h00, 1);
        end
        wrap_on = 1'b0;
        #1;
        out_ready = 1'b1;
        wait_drain("wrap");
        chk("wrap_pkt_count_0", pkt_count, 0);
        chk("wrap_no_overflow", overflow, 0);

        // Stray eop, then reset with a byte staged.
        do_reset();
        drive(0, 8'h00, 1);
        chk("stray_eop_valid", out_valid, 0);
        chk("stray_eop_pkt_count", pkt_count, 0);
        drive(1, 8'h55, 0);
        do_reset();
        chk("rst_mid_valid", out_valid, 0);
        drive(0, 8'h00, 1);
        @(posedge clk);
        #1;
        chk("rst_mid_eop_valid", out_valid, 0);
        chk("rst_mid_eop_pkt_count", pkt_count, 0);

        // Backpressure: head held stable while not accepted.
        out_ready = 1'b0;
        drive(1, 8'h66, 0);
        drive(1, 8'h77, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h66);
            chk("bp_last", out_last, 0);
        end
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 8'h66});
        exp_q.push_back({1'b1, 8'h77});
        drive(0, 8'h00, 1);
        out_ready = 1'b1;
        wait_drain("bp");
        chk("bp_pkt_count_0", pkt_count, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_pkt_fifo.md
# uart_rx_pkt_fifo

Receive-side packet buffer sitting directly downstream of the UART receiver. Accepts the receiver's one-cycle byte strobes and end-of-packet pulses, holds bytes in a FIFO tagged with a last-byte flag, and presents them to the consumer on a valid/ready stream. Tracks the number of complete packets buffered so a command parser can wait for a whole packet before draining.

## Interface
- `DEPTH`, 16: FIFO entries, power of 2, minimum 4.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `rx_ready`  in  1: one-cycle strobe, `rx_data` valid.
- `rx_data`  in  8: received byte.
- `rx_eop`  in  1: one-cycle end-of-packet pulse (line gap detected).
- `out_valid`  out  1: head entry available.
- `out_ready`  in  1: consumer accepts the head entry this cycle.
- `out_data`  out  8: head byte.
- `out_last`  out  1: head byte is the final byte of its packet.
- `pkt_count`  out  $clog2(DEPTH+1): complete packets (last-tagged entries) in the FIFO.
- `overflow`  out  1: sticky; a byte was dropped because the FIFO was full.

## Operation
- **Staging register.** The last flag is only known after the gap, so each received byte is held in `stg_data` with `stg_valid` until its fate is decided.
- **On `rx_ready`:**
  - If `stg_valid`, commit the staged byte with last=0.
  - Load `rx_data` into staging; set `stg_valid`.
- **On `rx_eop` with `stg_valid`:** commit the staged byte with last=1 and clear `stg_valid`.
- **On `rx_eop` without `stg_valid`:** ignored; no state change.
- **Simultaneous `rx_ready` and `rx_eop`:**
  - The eop applies to the currently staged byte, which is committed with last=1.
  - The new byte enters staging.
  - At most one commit occurs per cycle.
- **Commit:**
  - Writes {last, byte} to `mem[wr_ptr]` and advances `wr_ptr`.
  - If the FIFO is full (write-side full, evaluated before any same-cycle read), the entry is dropped, `overflow` is set, and the pointers are unchanged.
- **Read:** handshake is `out_valid && out_ready`; `rd_ptr` advances.
- **Simultaneous commit and read when full:** the commit is dropped. No pass-through.
- **Pointers:** `$clog2(DEPTH)+1` bits, wrapping naturally.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the remaining bits are equal.
- **`pkt_count`:**
  - +1 on a successful commit with last=1.
  - −1 on a read of an entry with `out_last`=1.
  - Both in the same cycle: unchanged.
  - Saturation is never reached, because count ≤ DEPTH.
- **`overflow`:** cleared only by `rst`.
- **Reset:** pointers 0, `stg_valid` 0, `pkt_count` 0, `overflow` 0.
  - Outputs after reset: `out_valid` 0, `out_last` 0, `out_data` 0 (memory contents are don't-care; `out_data` is gated to 0 when empty).
  - A reset during reception discards the staged byte and all buffered entries; the remainder of the interrupted packet is treated as a new packet.

## Timing
- First-word fall-through.
  - `out_valid`, `out_data` and `out_last` are driven combinationally from `mem[rd_ptr]` and the pointers.
  - Therefore they become valid the cycle after the commit edge.
- Byte latency, `rx_ready` to `out_valid`:
  - Mid-packet: until the next `rx_ready`, plus 1 cycle.
  - Final byte: until `rx_eop`, plus 1 cycle.
- `pkt_count` updates on the same edge as the commit or read that changes it.
- Throughput: one commit and one read per cycle.
- `out_data` and `out_last` are held stable while `out_valid && !out_ready`.
- `overflow` asserts the cycle after the dropped commit.

## Structure
- Shared package constants:
  - `RX_BYTE_W` = 8.
  - Entry-width `RX_ENTRY_W` = 9 ({last, data}).
- One natural sub-module: `sync_fifo`, a parameterised width/depth register-array FIFO with FWFT output, full/empty and write-when-full drop.
- The top level adds the staging register, the commit logic, `pkt_count` and `overflow`.

## Test plan
- **Single packet:** `rx_ready` with 0x41, 0x42, 0x43, then `rx_eop`, `out_ready`=1 → outputs 0x41/last 0, 0x42/last 0, 0x43/last 1; `pkt_count` goes 1 then 0.
- **Simultaneous:** `rx_ready`(0x10), then same-cycle `rx_ready`(0x20)+`rx_eop`, then `rx_eop` → two packets: {0x10 last=1}, {0x20 last=1}; `pkt_count`=2 before draining.
- **Overflow:** DEPTH=16, `out_ready`=0, commit 17 bytes → 16 entries buffered, the 17th is dropped, `overflow`=1 and stays 1 after the FIFO is drained; `rst` clears it.
- **Wrap-around:** 40 bytes in 4 packets of 10, with `out_ready` toggling at random → byte order and last flags exact; `pkt_count` never negative and returns to 0.
- **Stray eop and reset mid-packet:**
  - `rx_eop` with nothing staged → no entry, `pkt_count`=0.
  - Stage 0x55, assert `rst` → `out_valid` stays 0; a subsequent `rx_eop` creates no entry.
- **Backpressure:** `out_ready` held low for 3 cycles while `out_valid`=1 → `out_data` and `out_last` are unchanged over those cycles.
